stbus_clk_gen: RTL and testbench
================================

# stbus_clk_gen

Frame-locked, multi-channel clock/enable generator for the ST-bus side of the converter datapath. It locks to the active-low 8 kHz frame pulse `f0` in the `c4` (4.096 MHz) domain with a hunt/verify/flywheel state machine. It produces, per channel, a TX and an RX clock-enable strobe and a 50 %-duty derived clock with runtime-programmable divide ratio and RX phase offset. It is the parametrised successor to the fixed two-side (`_t`/`_n`) converter clocking, generalised to `N_CH` channels and adding lock supervision.

## Interface
- `N_CH`, 2, number of channels.
- `FRAME_LEN`, 512, `c4` cycles per frame.
- `CW`, 9, frame counter width (≥ clog2(FRAME_LEN)).
- `DIV_W`, 4, width of per-channel config fields.
- `LOCK_CNT`, 2, consecutive on-time markers (including the first) needed to lock.
- `MISS_MAX`, 3, consecutive missed markers that drop lock.

- `c4`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `f0`  in  1  frame pulse, active-low, synchronous to `c4`.
- `div_cfg`  in  N_CH*DIV_W  per-channel half-period minus 1: H = field+1, period P = 2H.
- `rx_ofs`  in  N_CH*DIV_W  per-channel RX phase offset in `c4` cycles.
- `frame_cnt`  out  CW  current frame position.
- `lock`  out  1  frame lock established.
- `frame_err`  out  1  one-cycle error pulse.
- `clk_en_tx`, `clk_en_rx`  out  N_CH each  one-cycle enable strobes.
- `clk_tx`, `clk_rx`  out  N_CH each  derived clocks.

## Operation
- Marker: `f0` sampled 0 at an edge where it was sampled 1 at the previous edge. A low level held for several cycles is one marker.
- `frame_cnt` increments every cycle and wraps FRAME_LEN-1 → 0. A marker is on time when its detecting edge is the wrap edge.
- States:
  - HUNT: `lock`=0. A marker forces `frame_cnt`←0, sets good=1 and moves to VERIFY. No `frame_err` is raised in HUNT.
  - VERIFY: at the wrap edge, an on-time marker increments good; when good reaches LOCK_CNT, go to LOCKED (`lock`←1). No marker at the wrap edge → HUNT plus `frame_err`. A marker at any other edge → `frame_cnt`←0, good=1, stay in VERIFY, plus `frame_err`.
  - LOCKED: at the wrap edge, an on-time marker clears miss. No marker → miss+1 plus `frame_err`; when miss reaches MISS_MAX, go to HUNT (`lock`←0). A misplaced marker raises `frame_err` only; `frame_cnt` and miss are unchanged (flywheel).
- Config: `div_cfg` and `rx_ofs` are latched per channel only at edges where `frame_cnt` becomes 0 (wrap or HUNT/VERIFY realign). If an offset is ≥ P, it is clamped to P-1.
- Channel phase: for each channel i, k = `frame_cnt` mod P_i (restarts every frame; the last period of a frame may be truncated).
  - `clk_en_tx[i]` = (k==0).
  - `clk_tx[i]` = (k<H).
  - `clk_en_rx[i]` = (k==ofs).
  - `clk_rx[i]` = (((k−ofs) mod P) < H).
- Gating: all four channel outputs are forced to 0 whenever `lock`=0.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Channel outputs are valid in the same cycle as the `frame_cnt` value they decode.
- Marker detect: at the detecting edge `frame_cnt` shows 0, so `frame_cnt`=0 is the `c4` cycle following the low sample of `f0`.
- Lock rises at the edge evaluating the LOCK_CNT-th on-time marker. The first enabled cycle therefore has `frame_cnt`=0 with every `clk_en_tx` = 1.
- Lock falls at the wrap edge of the MISS_MAX-th consecutive miss; channel outputs are 0 from that cycle. `frame_cnt` keeps free-running in HUNT.
- `frame_err` is high for exactly the one cycle after the offending edge.
- Reset (asynchronous, immediate, including mid-frame): state HUNT, `frame_cnt`=0, good=miss=0, latched config=0 (H=1, ofs=0), and every output is 0.

## Test plan
- Lock and basic clocks, with `f0` low for 1 cycle every 512 cycles:
  - Config: ch0 `div_cfg`=0, `rx_ofs`=1; ch1 `div_cfg`=3, `rx_ofs`=2.
  - `lock` rises at the 2nd marker.
  - ch0: `clk_tx` toggles every cycle; `clk_en_rx` at odd `frame_cnt`.
  - ch1: `clk_en_tx` at 0, 8, 16…; `clk_en_rx` at 2, 10…; `clk_rx` high at `frame_cnt` 2–5.
- Truncation: ch0 `div_cfg`=2 (P=6) → `clk_en_tx` at 504 and 510, then at 0; no strobe at 516.
- Flywheel:
  - Omit 2 markers → 2 `frame_err` pulses, `lock` stays 1, and the next on-time marker clears miss.
  - Omit 3 markers → `lock` falls at the 3rd missed wrap and outputs go to 0.
- Misplaced marker at `frame_cnt`=100:
  - In LOCKED → one `frame_err` pulse, `frame_cnt` undisturbed.
  - In VERIFY → `frame_cnt`=0 in the next cycle, and lock takes 1 further on-time marker.
- Config timing:
  - Change ch1 `div_cfg` 3→1 at `frame_cnt`=200 → the old period holds until 511, and the new period applies from `frame_cnt`=0.
  - `rx_ofs`=15 with H=2 → clamped to 3.
- Marker and reset edge cases:
  - `f0` held low for 5 cycles → a single marker.
  - Assert `rst_n`=0 at `frame_cnt`=300 → all outputs are 0 immediately; after release, relock takes 2 markers.

Source files
------------

// File: rtl/stbus_clk_gen.sv
`default_nettype none
// ============================================================================
//  Module      : stbus_clk_gen
//  Description : Frame-locked multi-channel clock/enable generator. Locks to
//                the active-low f0 frame pulse in the c4 domain and derives
//                per-channel TX/RX enables and 50% clocks.
//  Revision    : 1.0  initial release
// ============================================================================
module stbus_clk_gen #(
    parameter int N_CH      = 2,
    parameter int FRAME_LEN = 512,
    parameter int CW        = 9,
    parameter int DIV_W     = 4,
    parameter int LOCK_CNT  = 2,
    parameter int MISS_MAX  = 3
) (
    input  logic                   c4,
    input  logic                   rst_n,
    input  logic                   f0,
    input  logic [N_CH*DIV_W-1:0]  div_cfg,
    input  logic [N_CH*DIV_W-1:0]  rx_ofs,
    output logic [CW-1:0]          frame_cnt,
    output logic                   lock,
    output logic                   frame_err,
    output logic [N_CH-1:0]        clk_en_tx,
    output logic [N_CH-1:0]        clk_en_rx,
    output logic [N_CH-1:0]        clk_tx,
    output logic [N_CH-1:0]        clk_rx
);
    localparam int              c_hw       = DIV_W + 1;
    localparam int              c_pw       = DIV_W + 2;
    localparam int              c_gw       = $clog2(LOCK_CNT + 1);
    localparam int              c_mw       = $clog2(MISS_MAX + 1);
    localparam logic [CW-1:0]   c_last     = CW'(FRAME_LEN - 1);
    localparam logic [c_gw-1:0] c_lock_cnt = c_gw'(LOCK_CNT);
    localparam logic [c_mw-1:0] c_miss_max = c_mw'(MISS_MAX);

    typedef enum logic [1:0] {
        S_HUNT   = 2'd0,
        S_VERIFY = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [c_gw-1:0] good_q, good_d;
    logic [c_mw-1:0] miss_q, miss_d;
    logic            f0_q;
    logic            err_q, err_d;
    logic            lock_q;
    logic            w_marker, w_wrap, w_new_frame, w_lock_d;

    assign w_marker    = f0_q & ~f0;
    assign w_wrap      = (cnt_q == c_last);
    assign w_new_frame = (cnt_d == '0);
    assign w_lock_d    = (state_d == S_LOCKED);

    always_comb begin
        state_d = state_q;
        cnt_d   = w_wrap ? '0 : cnt_q + CW'(1);
        good_d  = good_q;
        miss_d  = miss_q;
        err_d   = 1'b0;
        case (state_q)
            S_HUNT: begin
                if (w_marker) begin
                    cnt_d   = '0;
                    good_d  = c_gw'(1);
                    state_d = S_VERIFY;
                end
            end
            S_VERIFY: begin
                if (w_wrap) begin
                    if (w_marker) begin
                        good_d = good_q + c_gw'(1);
                        if (good_d >= c_lock_cnt) begin
                            state_d = S_LOCKED;
                            miss_d  = '0;
                        end
                    end else begin
                        state_d = S_HUNT;
                        good_d  = '0;
                        err_d   = 1'b1;
                    end
                end else if (w_marker) begin
                    cnt_d  = '0;
                    good_d = c_gw'(1);
                    err_d  = 1'b1;
                end
            end
            S_LOCKED: begin
                // Misplaced markers are flagged but never move the flywheel.
                if (w_wrap) begin
                    if (w_marker) begin
                        miss_d = '0;
                    end else begin
                        miss_d = miss_q + c_mw'(1);
                        err_d  = 1'b1;
                        if (miss_d >= c_miss_max) begin
                            state_d = S_HUNT;
                            miss_d  = '0;
                        end
                    end
                end else if (w_marker) begin
                    err_d = 1'b1;
                end
            end
            default: state_d = S_HUNT;
        endcase
    end

    always_ff @(posedge c4 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_HUNT;
            cnt_q   <= '0;
            good_q  <= '0;
            miss_q  <= '0;
            f0_q    <= 1'b1;
            err_q   <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            good_q  <= good_d;
            miss_q  <= miss_d;
            f0_q    <= f0;
            err_q   <= err_d;
            lock_q  <= w_lock_d;
        end
    end

    assign frame_cnt = cnt_q;
    assign lock      = lock_q;
    assign frame_err = err_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [DIV_W-1:0] w_div, w_ofs_in;
        logic [c_hw-1:0]  w_h_in, h_q, h_d;
        logic [c_pw-1:0]  w_p_in, w_ofs_ext, w_ofs_cl, p_q, p_d;
        logic [c_pw-1:0]  ofs_q, ofs_d, k_q, k_d, w_rel;
        logic             etx_q, erx_q, tx_q, rx_q;

        assign w_div     = div_cfg[i*DIV_W +: DIV_W];
        assign w_ofs_in  = rx_ofs[i*DIV_W +: DIV_W];
        assign w_h_in    = {1'b0, w_div} + c_hw'(1);
        assign w_p_in    = {w_h_in, 1'b0};
        assign w_ofs_ext = {2'b00, w_ofs_in};
        assign w_ofs_cl  = (w_ofs_ext >= w_p_in) ? w_p_in - c_pw'(1) : w_ofs_ext;

        // The config taking effect at a frame start also decodes that cycle.
        assign h_d   = w_new_frame ? w_h_in : h_q;
        assign ofs_d = w_new_frame ? w_ofs_cl : ofs_q;
        assign p_d   = {h_d, 1'b0};
        assign p_q   = {h_q, 1'b0};
        assign k_d   = w_new_frame ? '0 :
                       (k_q == p_q - c_pw'(1)) ? '0 : k_q + c_pw'(1);
        assign w_rel = (k_d >= ofs_d) ? k_d - ofs_d : k_d + p_d - ofs_d;

        always_ff @(posedge c4 or negedge rst_n) begin
            if (!rst_n) begin
                h_q   <= c_hw'(1);
                ofs_q <= '0;
                k_q   <= '0;
                etx_q <= 1'b0;
                erx_q <= 1'b0;
                tx_q  <= 1'b0;
                rx_q  <= 1'b0;
            end else begin
                h_q   <= h_d;
                ofs_q <= ofs_d;
                k_q   <= k_d;
                etx_q <= w_lock_d & (k_d == '0);
                erx_q <= w_lock_d & (k_d == ofs_d);
                tx_q  <= w_lock_d & (k_d < {1'b0, h_d});
                rx_q  <= w_lock_d & (w_rel < {1'b0, h_d});
            end
        end

        assign clk_en_tx[i] = etx_q;
        assign clk_en_rx[i] = erx_q;
        assign clk_tx[i]    = tx_q;
        assign clk_rx[i]    = rx_q;
    end
endmodule
`default_nettype wire

// File: tb/tb_stbus_clk_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stbus_clk_gen
//  Description : Scoreboard bench for stbus_clk_gen against a frame-level
//                reference model; directed scenarios plus random frames.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_stbus_clk_gen;
    localparam int N_CH      = 2;
    localparam int FRAME_LEN = 512;
    localparam int CW        = 9;
    localparam int DIV_W     = 4;
    localparam int LOCK_CNT  = 2;
    localparam int MISS_MAX  = 3;
    localparam int MS_HUNT = 0, MS_VERIFY = 1, MS_LOCKED = 2;

    logic                  c4 = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  f0 = 1'b1;
    logic [N_CH*DIV_W-1:0] div_cfg = '0;
    logic [N_CH*DIV_W-1:0] rx_ofs = '0;
    logic [CW-1:0]         frame_cnt;
    logic                  lock, frame_err;
    logic [N_CH-1:0]       clk_en_tx, clk_en_rx, clk_tx, clk_rx;

    stbus_clk_gen #(
        .N_CH(N_CH), .FRAME_LEN(FRAME_LEN), .CW(CW), .DIV_W(DIV_W),
        .LOCK_CNT(LOCK_CNT), .MISS_MAX(MISS_MAX)
    ) dut (
        .c4(c4), .rst_n(rst_n), .f0(f0), .div_cfg(div_cfg), .rx_ofs(rx_ofs),
        .frame_cnt(frame_cnt), .lock(lock), .frame_err(frame_err),
        .clk_en_tx(clk_en_tx), .clk_en_rx(clk_en_rx),
        .clk_tx(clk_tx), .clk_rx(clk_rx)
    );

    always #5 c4 = ~c4;

    typedef struct packed {
        logic [CW-1:0]   cnt;
        logic            lock;
        logic            err;
        logic [N_CH-1:0] etx, erx, tx, rx;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   done = 1'b0;

    // Reference model state: frame position, lock state and latched config.
    int m_state = MS_HUNT, m_cnt = 0, m_good = 0, m_miss = 0, m_prev = 1, m_err = 0;
    int m_h[N_CH];
    int m_ofs[N_CH];

    task automatic model_reset();
        m_state = MS_HUNT; m_cnt = 0; m_good = 0; m_miss = 0; m_prev = 1; m_err = 0;
        for (int i = 0; i < N_CH; i++) begin
            m_h[i] = 1; m_ofs[i] = 0;
        end
    endtask

    task automatic model_step();
        int marker, wrap, p, o;
        marker = (m_prev == 1 && f0 == 1'b0) ? 1 : 0;
        m_prev = (f0 == 1'b1) ? 1 : 0;
        wrap   = (m_cnt == FRAME_LEN - 1) ? 1 : 0;
        m_err  = 0;
        m_cnt  = (m_cnt + 1) % FRAME_LEN;
        case (m_state)
            MS_HUNT: if (marker != 0) begin
                m_cnt = 0; m_good = 1; m_state = MS_VERIFY;
            end
            MS_VERIFY: begin
                if (wrap != 0) begin
                    if (marker != 0) begin
                        m_good++;
                        if (m_good >= LOCK_CNT) begin m_state = MS_LOCKED; m_miss = 0; end
                    end else begin
                        m_state = MS_HUNT; m_err = 1;
                    end
                end else if (marker != 0) begin
                    m_cnt = 0; m_good = 1; m_err = 1;
                end
            end
            default: begin
                if (wrap != 0) begin
                    if (marker != 0) m_miss = 0;
                    else begin
                        m_miss++; m_err = 1;
                        if (m_miss >= MISS_MAX) m_state = MS_HUNT;
                    end
                end else if (marker != 0) begin
                    m_err = 1;
                end
            end
        endcase
        if (m_cnt == 0) begin
            for (int i = 0; i < N_CH; i++) begin
                m_h[i] = int'(div_cfg[i*DIV_W +: DIV_W]) + 1;
                p = 2 * m_h[i];
                o = int'(rx_ofs[i*DIV_W +: DIV_W]);
                m_ofs[i] = (o >= p) ? p - 1 : o;
            end
        end
    endtask

    function automatic obs_t model_out();
        obs_t e;
        int   p, k;
        e      = '0;
        e.cnt  = CW'(m_cnt);
        e.lock = (m_state == MS_LOCKED);
        e.err  = (m_err != 0);
        for (int i = 0; i < N_CH; i++) begin
            p = 2 * m_h[i];
            k = m_cnt % p;
            if (e.lock) begin
                e.etx[i] = (k == 0);
                e.tx[i]  = (k < m_h[i]);
                e.erx[i] = (k == m_ofs[i]);
                e.rx[i]  = (((k - m_ofs[i] + p) % p) < m_h[i]);
            end
        end
        return e;
    endfunction

    always @(posedge c4) begin
        if (!rst_n) model_reset();
        else        model_step();
        exp_q.push_back(model_out());
    end

    always @(negedge c4) begin
        obs_t a, e;
        if (!done) begin
            a.cnt = frame_cnt; a.lock = lock; a.err = frame_err;
            a.etx = clk_en_tx; a.erx = clk_en_rx; a.tx = clk_tx; a.rx = clk_rx;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL scoreboard_empty at t=%0t", $time);
            end else begin
                e = exp_q.pop_front();
                if (!rst_n) e = '0;
                if (a !== e) begin
                    n_errors++;
                    $display("FAIL outputs t=%0t got cnt=%0d lock=%b err=%b etx=%b erx=%b tx=%b rx=%b want cnt=%0d lock=%b err=%b etx=%b erx=%b tx=%b rx=%b",
                             $time, a.cnt, a.lock, a.err, a.etx, a.erx, a.tx, a.rx,
                             e.cnt, e.lock, e.err, e.etx, e.erx, e.tx, e.rx);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge c4);
        #2;
    endtask

    task automatic goto_cnt(input int c);
        int n;
        n = 0;
        while (m_cnt != c) begin
            tick();
            n++;
            if (n > 2 * FRAME_LEN) begin
                n_checks++; n_errors++;
                $display("FAIL goto_cnt timeout: got cnt %0d want %0d", m_cnt, c);
                return;
            end
        end
    endtask

    task automatic pulse(input int pos, input int len);
        goto_cnt(pos);
        f0 = 1'b0;
        repeat (len) tick();
        f0 = 1'b1;
    endtask

    task automatic no_marker();
        goto_cnt(FRAME_LEN - 1);
        tick();
    endtask

    task automatic set_cfg(input int ch, input int d, input int o);
        div_cfg[ch*DIV_W +: DIV_W] = DIV_W'(d);
        rx_ofs[ch*DIV_W +: DIV_W]  = DIV_W'(o);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) tick();
        @(negedge c4);
        check("reset_outputs", {frame_cnt, lock, frame_err, clk_en_tx, clk_tx}, '0);
        tick();
        rst_n = 1'b1;
        set_cfg(0, 0, 1);
        set_cfg(1, 3, 2);

        // Acquire lock.
        pulse(FRAME_LEN - 1, 1);
        @(negedge c4);
        check("lock_after_1st", lock, 1'b0);
        pulse(FRAME_LEN - 1, 1);
        @(negedge c4);
        check("lock_after_2nd", lock, 1'b1);
        check("first_cnt", frame_cnt, 0);
        check("first_en_tx", clk_en_tx, 2'b11);
        goto_cnt(3);  @(negedge c4); check("ch1_rx_at3", clk_rx[1], 1'b1);
        goto_cnt(6);  @(negedge c4); check("ch1_rx_at6", clk_rx[1], 1'b0);
        goto_cnt(7);  @(negedge c4); check("ch0_erx_at7", clk_en_rx[0], 1'b1);
        goto_cnt(10); @(negedge c4); check("ch1_erx_at10", clk_en_rx[1], 1'b1);
        pulse(FRAME_LEN - 1, 1);

        // Truncated last period on ch0.
        set_cfg(0, 2, 1);
        pulse(FRAME_LEN - 1, 1);
        goto_cnt(504); @(negedge c4); check("trunc_etx_504", clk_en_tx[0], 1'b1);
        goto_cnt(510); @(negedge c4); check("trunc_etx_510", clk_en_tx[0], 1'b1);
        pulse(FRAME_LEN - 1, 1);
        @(negedge c4); check("trunc_etx_0", clk_en_tx[0], 1'b1);
        goto_cnt(4);   @(negedge c4); check("trunc_etx_4", clk_en_tx[0], 1'b0);

        // Flywheel: two misses keep lock; an on-time marker clears the count.
        no_marker(); @(negedge c4);
        check("miss1_err", frame_err, 1'b1);
        no_marker(); @(negedge c4);
        check("miss2_lock", lock, 1'b1);
        pulse(FRAME_LEN - 1, 1); @(negedge c4);
        check("ontime_no_err", frame_err, 1'b0);
        no_marker();
        no_marker(); @(negedge c4);
        check("miss_cleared_lock", lock, 1'b1);
        pulse(FRAME_LEN - 1, 1);

        // Misplaced marker while locked.
        pulse(100, 1); @(negedge c4);
        check("locked_mis_err", frame_err, 1'b1);
        check("locked_mis_cnt", frame_cnt, 101);
        pulse(FRAME_LEN - 1, 1);

        // Config change mid-frame on ch1, with offset clamp.
        goto_cnt(200);
        set_cfg(1, 1, 15);
        goto_cnt(258); @(negedge c4); check("old_cfg_erx_258", clk_en_rx[1], 1'b1);
        pulse(FRAME_LEN - 1, 1);
        goto_cnt(3); @(negedge c4); check("clamp_erx_3", clk_en_rx[1], 1'b1);
        goto_cnt(7); @(negedge c4); check("clamp_erx_7", clk_en_rx[1], 1'b1);

        // Long low f0 is one marker.
        pulse(FRAME_LEN - 1, 5); @(negedge c4);
        check("long_low_err", frame_err, 1'b0);
        check("long_low_lock", lock, 1'b1);

        // Three misses drop lock.
        no_marker();
        no_marker();
        no_marker(); @(negedge c4);
        check("lost_lock", lock, 1'b0);
        check("lost_etx", clk_en_tx, 2'b00);

        // Misplaced marker in VERIFY realigns; one more on-time marker locks.
        pulse(FRAME_LEN - 1, 1);
        pulse(100, 1); @(negedge c4);
        check("verify_mis_cnt", frame_cnt, 0);
        check("verify_mis_err", frame_err, 1'b1);
        pulse(FRAME_LEN - 1, 1); @(negedge c4);
        check("verify_relock", lock, 1'b1);

        // Asynchronous reset mid-frame.
        goto_cnt(300);
        rst_n = 1'b0;
        #1;
        check("async_reset", {frame_cnt, lock, clk_en_tx, clk_en_rx, clk_tx, clk_rx}, '0);
        tick(); tick();
        rst_n = 1'b1;
        pulse(FRAME_LEN - 1, 1); @(negedge c4);
        check("relock_1st", lock, 1'b0);
        pulse(FRAME_LEN - 1, 1); @(negedge c4);
        check("relock_2nd", lock, 1'b1);

        // Random frames.
        for (int f = 0; f < 12; f++) begin
            int r;
            r = int'($urandom_range(0, 9));
            set_cfg(int'($urandom_range(0, N_CH - 1)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 15)));
            if (r < 6)      pulse(FRAME_LEN - 1, int'($urandom_range(1, 4)));
            else if (r < 8) no_marker();
            else            pulse(int'($urandom_range(20, 400)), int'($urandom_range(1, 3)));
        end

        repeat (4) tick();
        @(negedge c4);
        #1;
        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
